ram_port_arbiter: RTL and testbench

- Shares the single-port 256x8 data RAM between two requesters: port A (CPU load/store path, FSM-driven) and port B (program/data loader or debug DMA).
- Port A has fixed priority. A fairness counter guarantees port B a grant after at most MAX_CONSEC back-to-back A grants.
- Sits between the requesters and the RAM. It drives the RAM write_enable/address/data_in and returns the RAM's 1-cycle synchronous read data to the requester that issued the read.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/rr_fair_counter.sv | 33 +++
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-RAM port arbiter: default bus widths
// and the encoding that tags which requester owns the read in flight.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;   // wide enough for MAX_CONSEC up to 15

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_fair_counter.sv
// Fairness counter: counts consecutive port-A grants while port B waits
// and raises force_b once A has had its MAX_CONSEC turns in a row.
module rr_fair_counter
    import cpu_pkg::*;
#(
    parameter int MAX_CONSEC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_gnt,
    input  logic b_gnt,
    input  logic b_req,
    output logic force_b
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONSEC);

    logic [CNT_W-1:0] count_reg;

    // Count A grants that made B wait; any B grant or idle B clears the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (!b_req || b_gnt) begin
            count_reg <= '0;
        end else if (a_gnt && (count_reg != MAX_C)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign force_b = (count_reg == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM. Port A wins by
// default; the fairness counter hands B a slot after MAX_CONSEC A wins.
// Read data returns one cycle after the grant, steered by an owner tag.
module ram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              force_b;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] wdata_hold_reg;
    logic [DATA_W-1:0] a_rdata_reg;
    logic [DATA_W-1:0] b_rdata_reg;
    owner_t            owner_reg;

    rr_fair_counter #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_fair (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt),
        .b_req   (b_req),
        .force_b (force_b)
    );

    // Grant decision: A unless B is owed a turn; nothing while in reset.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && !(b_req && force_b)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // RAM drive: granted port passes straight through; idle cycles keep the
    // last address/data so the RAM inputs do not toggle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_hold_reg;
        ram_wdata = wdata_hold_reg;
        if (a_gnt) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    // Remember the last granted address/data for idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else if (a_gnt || b_gnt) begin
            addr_hold_reg  <= ram_addr;
            wdata_hold_reg <= ram_wdata;
        end
    end

    // Read-return tag FSM: follows the current grant every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_NONE;
        end else begin
            case (1'b1)
                (a_gnt && !a_we): owner_reg <= OWN_A;
                (b_gnt && !b_we): owner_reg <= OWN_B;
                default:          owner_reg <= OWN_NONE;
            endcase
        end
    end

    // Capture returned data so each port's rdata holds after rvalid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            if (owner_reg == OWN_A) a_rdata_reg <= ram_rdata;
            if (owner_reg == OWN_B) b_rdata_reg <= ram_rdata;
        end
    end

    assign a_rvalid = (owner_reg == OWN_A);
    assign b_rvalid = (owner_reg == OWN_B);
    assign a_rdata  = a_rvalid ? ram_rdata : a_rdata_reg;
    assign b_rdata  = b_rvalid ? ram_rdata : b_rdata_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, a spec-level reference
// model for grants/RAM drive, and a scoreboard for read returns.
module tb_ram_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int MAX = 4;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_CONSEC (MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous read, output held on writes.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model state.
    typedef struct { logic [DW-1:0] data; int cyc; } rd_t;
    rd_t           a_q[$];
    rd_t           b_q[$];
    logic [DW-1:0] ref_mem [256];
    int            m_count = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;

    // Model: expected grant and RAM drive each cycle, queue expected reads.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_a_gnt", a_gnt, 0);
            check("rst_b_gnt", b_gnt, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            m_count = 0;
            m_addr  = '0;
            m_wdata = '0;
        end else begin
            bit ga, gb, we;
            ga = a_req && !(b_req && (m_count == MAX));
            gb = b_req && !ga;
            we = 1'b0;
            if (ga) begin we = a_we; m_addr = a_addr; m_wdata = a_wdata; end
            if (gb) begin we = b_we; m_addr = b_addr; m_wdata = b_wdata; end
            check("a_gnt", a_gnt, ga);
            check("b_gnt", b_gnt, gb);
            check("ram_we", ram_we, we);
            check("ram_addr", ram_addr, m_addr);
            check("ram_wdata", ram_wdata, m_wdata);
            if (ga || gb) begin
                $display("cycle %0d: grant %s %s addr=%02h wdata=%02h", cyc,
                         ga ? "A" : "B", we ? "WR" : "RD", m_addr, m_wdata);
                if (we) ref_mem[m_addr] = m_wdata;
                else if (ga) a_q.push_back('{ref_mem[m_addr], cyc});
                else         b_q.push_back('{ref_mem[m_addr], cyc});
            end
            if (!b_req || gb)              m_count = 0;
            else if (ga && m_count < MAX)  m_count++;
        end
    end

    // Monitor: pops expected read data when the DUT returns it.
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_q.delete();
            b_q.delete();
            last_a = '0;
            last_b = '0;
            check("rst_a_rvalid", a_rvalid, 0);
            check("rst_b_rvalid", b_rvalid, 0);
            check("rst_a_rdata", a_rdata, 0);
            check("rst_b_rdata", b_rdata, 0);
        end else begin
            bit ea, eb;
            ea = (a_q.size() > 0) && (a_q[0].cyc < cyc);
            eb = (b_q.size() > 0) && (b_q[0].cyc < cyc);
            check("a_rvalid", a_rvalid, ea);
            check("b_rvalid", b_rvalid, eb);
            if (ea) begin
                last_a = a_q[0].data;
                void'(a_q.pop_front());
                $display("cycle %0d: A read return %02h (expect %02h)", cyc, a_rdata, last_a);
            end
            if (eb) begin
                last_b = b_q[0].data;
                void'(b_q.pop_front());
                $display("cycle %0d: B read return %02h (expect %02h)", cyc, b_rdata, last_b);
            end
            check("a_rdata", a_rdata, last_a);
            check("b_rdata", b_rdata, last_b);
        end
    end

    task automatic step(input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] ad,
                        input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    logic [9:0] b_seq;
    logic [9:0] b_seq_exp;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_rdata = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // A-only write then read-after-write of the same address.
        step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        idle(2);

        // Simultaneous: A reads 0x20, B writes 0x21; B waits one cycle.
        step(1, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h20, 8'h00, 1, 1, 8'h21, 8'h33);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h33);
        step(1, 0, 8'h21, 8'h00, 0, 0, 8'h00, 8'h00);
        idle(2);

        // Routing: back-to-back reads from A then B.
        step(1, 1, 8'h00, 8'hAA, 0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 8'hBB);
        step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);
        idle(2);

        // Idle hold after a write to 0x7F.
        step(1, 1, 8'h7F, 8'hC3, 0, 0, 8'h00, 8'h00);
        idle(5);

        // Fairness with both requesters held: A,A,A,A,B,A,A,A,A,B.
        b_seq = '0;
        for (int i = 0; i < 10; i++) begin
            a_req = 1; a_we = 0; a_addr = 8'(i); a_wdata = '0;
            b_req = 1; b_we = 0; b_addr = 8'(8'h40 + i); b_wdata = '0;
            @(negedge clk);
            b_seq[i] = b_gnt;
            @(posedge clk);
            #1;
        end
        b_seq_exp = 10'h210;
        check("fair_seq", 32'(b_seq), 32'(b_seq_exp));
        idle(2);

        // Reset while a read is granted but before its data returns.
        a_req = 1; a_we = 0; a_addr = 8'h10; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Randomized traffic on a small address window.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
